sal_addr_router: RTL and testbench

Parametrised request router between the AXI read/write address channels and the per-bank DDR2 controllers. Each cycle it arbitrates between AR and AW, decodes the winning address into bank/row/column fields, and pushes the request into a small per-bank queue. The queues decouple AXI handshakes from bank-controller back-pressure, so one stalled bank does not block requests to other banks. It sits directly in front of the `BK_CNT` bank controllers and replaces the read-only combinational decoder.

---
 rtl/sal_addr_router.sv | 141 ++++++++++++++
 tb/tb_sal_addr_router.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sal_addr_router.sv
// AXI AR/AW to per-bank DDR2 request router: round-robin AR/AW arbitration,
// address decode and one small FIFO per bank. Optional macro: SAL_ADDR_BA_XOR_EN.
module sal_addr_router #(
    parameter int BK_CNT       = 4,
    parameter int ADDR_WIDTH   = 32,
    parameter int ID_WIDTH     = 4,
    parameter int LEN_WIDTH    = 4,
    parameter int OFFSET_WIDTH = 3,
    parameter int CA_WIDTH     = 10,
    parameter int RA_WIDTH     = 14,
    parameter int Q_DEPTH      = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDR_WIDTH-1:0]         araddr,
    input  logic [ID_WIDTH-1:0]           arid,
    input  logic [LEN_WIDTH-1:0]          arlen,
    input  logic                          arvalid,
    output logic                          arready,
    input  logic [ADDR_WIDTH-1:0]         awaddr,
    input  logic [ID_WIDTH-1:0]           awid,
    input  logic [LEN_WIDTH-1:0]          awlen,
    input  logic                          awvalid,
    output logic                          awready,
    output logic [BK_CNT-1:0]             bk_req_valid,
    input  logic [BK_CNT-1:0]             bk_req_ready,
    output logic [BK_CNT*ID_WIDTH-1:0]    bk_req_id,
    output logic [BK_CNT*RA_WIDTH-1:0]    bk_req_ra,
    output logic [BK_CNT*CA_WIDTH-1:0]    bk_req_ca,
    output logic [BK_CNT*LEN_WIDTH-1:0]   bk_req_len,
    output logic [BK_CNT-1:0]             bk_req_wr
);
    localparam int BA_WIDTH = $clog2(BK_CNT);
    localparam int PW       = $clog2(Q_DEPTH);
    localparam int CW       = PW + 1;
    localparam int CA_LSB   = OFFSET_WIDTH;
    localparam int BA_LSB   = OFFSET_WIDTH + CA_WIDTH;
    localparam int RA_LSB   = OFFSET_WIDTH + CA_WIDTH + BA_WIDTH;

    typedef struct packed {
        logic [ID_WIDTH-1:0]  id;
        logic [RA_WIDTH-1:0]  ra;
        logic [CA_WIDTH-1:0]  ca;
        logic [LEN_WIDTH-1:0] len;
        logic                 wr;
    } req_t;

    function automatic logic [BA_WIDTH-1:0] f_bank(input logic [ADDR_WIDTH-1:0] a);
        logic [BA_WIDTH-1:0] ba;
        ba = a[BA_LSB +: BA_WIDTH];
`ifdef SAL_ADDR_BA_XOR_EN
        // Fold the low row bits in so row-strided streams hit different banks.
        ba = ba ^ a[RA_LSB +: BA_WIDTH];
`endif
        return ba;
    endfunction

    logic [BA_WIDTH-1:0] w_ar_bank, w_aw_bank, w_push_bank;
    logic [BK_CNT-1:0]   w_full;
    logic                w_ar_elig, w_aw_elig, w_gnt_ar, w_gnt_aw, w_push_any;
    logic                r_prio;
    req_t                w_ar_req, w_aw_req, w_push_req;
    logic                w_unused;

    assign w_unused  = ^{araddr, awaddr};
    assign w_ar_bank = f_bank(araddr);
    assign w_aw_bank = f_bank(awaddr);

    assign w_ar_elig = arvalid & ~w_full[w_ar_bank] & ~rst;
    assign w_aw_elig = awvalid & ~w_full[w_aw_bank] & ~rst;
    assign w_gnt_ar  = w_ar_elig & (~w_aw_elig | ~r_prio);
    assign w_gnt_aw  = w_aw_elig & ~w_gnt_ar;
    assign arready   = w_gnt_ar;
    assign awready   = w_gnt_aw;

    always_comb begin
        w_ar_req     = '0;
        w_ar_req.id  = arid;
        w_ar_req.ra  = araddr[RA_LSB +: RA_WIDTH];
        w_ar_req.ca  = araddr[CA_LSB +: CA_WIDTH];
        w_ar_req.len = arlen;
        w_ar_req.wr  = 1'b0;
        w_aw_req     = '0;
        w_aw_req.id  = awid;
        w_aw_req.ra  = awaddr[RA_LSB +: RA_WIDTH];
        w_aw_req.ca  = awaddr[CA_LSB +: CA_WIDTH];
        w_aw_req.len = awlen;
        w_aw_req.wr  = 1'b1;
    end

    assign w_push_any  = w_gnt_ar | w_gnt_aw;
    assign w_push_req  = w_gnt_aw ? w_aw_req : w_ar_req;
    assign w_push_bank = w_gnt_aw ? w_aw_bank : w_ar_bank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_prio <= 1'b0;
        else if (w_gnt_ar)
            r_prio <= 1'b1;
        else if (w_gnt_aw)
            r_prio <= 1'b0;
    end

    for (genvar g = 0; g < BK_CNT; g++) begin : g_bank
        req_t [Q_DEPTH-1:0] r_mem;
        logic [PW-1:0]      r_wp, r_rp;
        logic [CW-1:0]      r_cnt;
        logic               w_push, w_pop;
        req_t               w_head;

        assign w_push    = w_push_any & (w_push_bank == BA_WIDTH'(g));
        assign w_pop     = (r_cnt != '0) & bk_req_ready[g];
        // Full comes from the registered count: a same-cycle pop never frees a slot.
        assign w_full[g] = (r_cnt == CW'(Q_DEPTH));
        assign w_head    = r_mem[r_rp];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_mem <= '0;
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_mem[r_wp] <= w_push_req;
                    r_wp        <= r_wp + 1'b1;
                end
                if (w_pop)
                    r_rp <= r_rp + 1'b1;
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end

        assign bk_req_valid[g]                        = (r_cnt != '0);
        assign bk_req_id [g*ID_WIDTH  +: ID_WIDTH]    = w_head.id;
        assign bk_req_ra [g*RA_WIDTH  +: RA_WIDTH]    = w_head.ra;
        assign bk_req_ca [g*CA_WIDTH  +: CA_WIDTH]    = w_head.ca;
        assign bk_req_len[g*LEN_WIDTH +: LEN_WIDTH]   = w_head.len;
        assign bk_req_wr[g]                           = w_head.wr;
    end
endmodule

// File: tb/tb_sal_addr_router.sv
// Directed bench for sal_addr_router: vector table plus hand sequences.
module tb_sal_addr_router;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] araddr, awaddr;
    logic [3:0]  arid, arlen, awid, awlen;
    logic        arvalid, awvalid, arready, awready;
    logic [3:0]  bk_req_valid, bk_req_ready, bk_req_wr;
    logic [15:0] bk_req_id, bk_req_len;
    logic [55:0] bk_req_ra;
    logic [39:0] bk_req_ca;

    int n_cmp = 0;
    int n_err = 0;

    sal_addr_router dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arvalid(arvalid), .arready(arready),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awvalid(awvalid), .awready(awready),
        .bk_req_valid(bk_req_valid), .bk_req_ready(bk_req_ready),
        .bk_req_id(bk_req_id), .bk_req_ra(bk_req_ra), .bk_req_ca(bk_req_ca),
        .bk_req_len(bk_req_len), .bk_req_wr(bk_req_wr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        arv;
        logic [31:0] ara;
        logic        awv;
        logic [31:0] awa;
        logic [3:0]  rdy;
        logic        earr;
        logic        eawr;
        logic [3:0]  evld;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(input logic arv, input logic [31:0] ara, input logic awv,
                                input logic [31:0] awa, input logic [3:0] rdy,
                                input logic earr, input logic eawr, input logic [3:0] evld);
        vec_t v;
        v.arv = arv; v.ara = ara; v.awv = awv; v.awa = awa; v.rdy = rdy;
        v.earr = earr; v.eawr = eawr; v.evld = evld;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle();
        arvalid = 0; araddr = '0; arid = '0; arlen = '0;
        awvalid = 0; awaddr = '0; awid = '0; awlen = '0;
        bk_req_ready = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    initial begin
        // Bank b at row 0: addr = b << 13.
        tbl[0]  = mk(0, 32'h0,    0, 32'h0,    4'b0000, 0, 0, 4'b0000);
        tbl[1]  = mk(1, 32'h2008, 0, 32'h0,    4'b0000, 1, 0, 4'b0010);
        tbl[2]  = mk(0, 32'h0,    0, 32'h0,    4'b0010, 0, 0, 4'b0000);
        tbl[3]  = mk(0, 32'h0,    1, 32'h4000, 4'b0000, 0, 1, 4'b0100);
        tbl[4]  = mk(0, 32'h0,    1, 32'h4000, 4'b0000, 0, 1, 4'b0100);
        tbl[5]  = mk(0, 32'h0,    1, 32'h4000, 4'b0000, 0, 0, 4'b0100);
        tbl[6]  = mk(0, 32'h0,    1, 32'h4000, 4'b0100, 0, 0, 4'b0100);
        tbl[7]  = mk(0, 32'h0,    1, 32'h4000, 4'b0000, 0, 1, 4'b0100);
        tbl[8]  = mk(1, 32'h4000, 1, 32'h6000, 4'b0000, 0, 1, 4'b1100);
        tbl[9]  = mk(1, 32'h0,    1, 32'h2000, 4'b0000, 1, 0, 4'b1101);
        tbl[10] = mk(0, 32'h0,    1, 32'h2000, 4'b0000, 0, 1, 4'b1111);
        tbl[11] = mk(1, 32'h0,    1, 32'h0,    4'b0000, 1, 0, 4'b1111);
        tbl[12] = mk(1, 32'h2000, 1, 32'h0,    4'b1111, 1, 0, 4'b0111);
        tbl[13] = mk(0, 32'h0,    1, 32'h0,    4'b0000, 0, 1, 4'b0111);
        tbl[14] = mk(0, 32'h0,    0, 32'h0,    4'b1111, 0, 0, 4'b0001);
        tbl[15] = mk(0, 32'h0,    0, 32'h0,    4'b0001, 0, 0, 4'b0000);

        idle();
        arvalid = 1;
        araddr  = 32'h2008;
        #2;
        chk("rst_arready", {63'b0, arready}, 64'd0);
        chk("rst_valid",   {60'b0, bk_req_valid}, 64'd0);
        chk("rst_id",      {48'b0, bk_req_id}, 64'd0);
        chk("rst_ra",      {8'b0, bk_req_ra}, 64'd0);
        idle();
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            arvalid = tbl[i].arv; araddr = tbl[i].ara; arid = 4'(i);
            awvalid = tbl[i].awv; awaddr = tbl[i].awa; awid = 4'(i);
            bk_req_ready = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d_arready", i), {63'b0, arready}, {63'b0, tbl[i].earr});
            chk($sformatf("v%0d_awready", i), {63'b0, awready}, {63'b0, tbl[i].eawr});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {60'b0, bk_req_valid}, {60'b0, tbl[i].evld});
        end

        // Single AR decode and payload on bank 1.
        @(negedge clk);
        do_reset();
        arvalid = 1; araddr = 32'h0000_2008; arid = 4'd3; arlen = 4'd1;
        #1;
        chk("dec_arready", {63'b0, arready}, 64'd1);
        @(posedge clk); #1;
        chk("dec_valid", {60'b0, bk_req_valid}, 64'b0010);
        chk("dec_id",    {60'b0, bk_req_id[7:4]}, 64'd3);
        chk("dec_ra",    {50'b0, bk_req_ra[27:14]}, 64'd0);
        chk("dec_ca",    {54'b0, bk_req_ca[19:10]}, 64'd1);
        chk("dec_len",   {60'b0, bk_req_len[7:4]}, 64'd1);
        chk("dec_wr",    {63'b0, bk_req_wr[1]}, 64'd0);

        // AR/AW alternation into bank 0, drained every cycle.
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            arvalid = 1; araddr = 32'h0; arid = 4'(i);
            awvalid = 1; awaddr = 32'h0; awid = 4'(8 + i);
            bk_req_ready = 4'b0001;
            #1;
            chk($sformatf("alt%0d_arready", i), {63'b0, arready}, {63'b0, (i % 2 == 0)});
            chk($sformatf("alt%0d_awready", i), {63'b0, awready}, {63'b0, (i % 2 == 1)});
            @(posedge clk); #1;
            chk($sformatf("alt%0d_wr", i), {63'b0, bk_req_wr[0]}, {63'b0, (i % 2 == 1)});
            chk($sformatf("alt%0d_id", i), {60'b0, bk_req_id[3:0]}, (i % 2 == 1) ? 64'(8 + i) : 64'(i));
            @(negedge clk);
        end

        // Row-1, BA-field-1 address: bank choice depends on the XOR build.
        do_reset();
        arvalid = 1; araddr = 32'h0000_A000; arid = 4'd1;
        @(posedge clk); #1;
`ifdef SAL_ADDR_BA_XOR_EN
        chk("xor_bank", {60'b0, bk_req_valid}, 64'b0001);
`else
        chk("xor_bank", {60'b0, bk_req_valid}, 64'b0010);
`endif

        // Mid-cycle reset discards queued requests at once.
        @(negedge clk);
        do_reset();
        arvalid = 1; araddr = 32'h0; awvalid = 1; awaddr = 32'h2000;
        @(negedge clk);
        arvalid = 0;
        @(negedge clk);
        awvalid = 0; arvalid = 1; araddr = 32'h4000;
        @(negedge clk);
        chk("mr_queued", {60'b0, bk_req_valid}, 64'b0111);
        arvalid = 1; araddr = 32'h6000;
        #2;
        rst = 1;
        #1;
        chk("mr_valid_drop", {60'b0, bk_req_valid}, 64'd0);
        chk("mr_arready",    {63'b0, arready}, 64'd0);
        @(negedge clk);
        rst = 0;
        arvalid = 1; araddr = 32'h0; awvalid = 1; awaddr = 32'h2000;
        #1;
        chk("mr_prio_ar", {62'b0, arready, awready}, 64'b10);
        @(posedge clk); #1;
        chk("mr_after", {60'b0, bk_req_valid}, 64'b0001);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
